data_mem_mmio: RTL and testbench

//  Data-memory stage consumed by the single-cycle mips core: takes alu_result as byte address,

---
 rtl/data_mem_mmio_if.sv | 21 ++
 rtl/data_mem_mmio.sv | 111 +++++++++++
 tb/tb_data_mem_mmio.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_mmio_if.sv
// Load/store bus between the core's memory stage and data_mem_mmio.
// master = core side, slave = memory side.
interface data_mem_mmio_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] write_data;
    logic             mem_write;
    logic [WIDTH-1:0] read_data;
    logic             misaligned;

    modport master (
        output addr, write_data, mem_write,
        input  read_data, misaligned
    );

    modport slave (
        input  addr, write_data, mem_write,
        output read_data, misaligned
    );
endinterface

// File: rtl/data_mem_mmio.sv
// Single-cycle data memory: word RAM plus MMIO window (GPIO, timer).
// Timer (CNT/CMP/STAT) is built only when DMEM_TIMER_EN is defined.
module data_mem_mmio #(
    parameter int          WIDTH      = 32,
    parameter int          DEPTH_BITS = 6,
    parameter logic [15:0] MMIO_HI    = 16'hFFFF
) (
    input  logic             clk,
    input  logic             reset,
    data_mem_mmio_if.slave   bus,
    output logic [WIDTH-1:0] gpio_out,
    output logic             timer_irq
);
    localparam int WORDS = 1 << DEPTH_BITS;

    logic [WIDTH-1:0]      ram [0:WORDS-1];
    logic [DEPTH_BITS-1:0] ram_idx;
    logic [15:0]           off;
    logic                  mmio_sel;
    logic                  store_ok;
    logic                  ram_we;
    logic                  mmio_we;
    logic                  is_gpio;
    logic [WIDTH-1:0]      gpio_q;
    logic [WIDTH-1:0]      rdata;

    assign mmio_sel = bus.addr[WIDTH-1:WIDTH-16] == MMIO_HI;
    assign ram_idx  = bus.addr[DEPTH_BITS+1:2];
    assign off      = bus.addr[15:0];
    assign is_gpio  = off == 16'h0000;

    assign bus.misaligned = bus.mem_write & (bus.addr[1:0] != 2'b00);

    // Stores in the reset cycle or with a bad alignment never land anywhere
    assign store_ok = bus.mem_write & ~bus.misaligned & ~reset;
    assign ram_we   = store_ok & ~mmio_sel;
    assign mmio_we  = store_ok & mmio_sel;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= bus.write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_q <= '0;
        end else if (mmio_we && is_gpio) begin
            gpio_q <= bus.write_data;
        end
    end

    assign gpio_out = gpio_q;

`ifdef DMEM_TIMER_EN
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic             is_cnt;
    logic             is_cmp;
    logic             is_stat;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cmp_q;
    logic             flag_q;

    assign is_cnt  = off == 16'h0004;
    assign is_cmp  = off == 16'h0008;
    assign is_stat = off == 16'h000C;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            cmp_q  <= '1;
            flag_q <= 1'b0;
        end else begin
            cnt_q <= (mmio_we && is_cnt) ? bus.write_data : cnt_q + ONE;
            if (mmio_we && is_cmp) begin
                cmp_q <= bus.write_data;
            end
            // A match on the same edge as a W1C clear keeps the flag set
            if (cnt_q == cmp_q) begin
                flag_q <= 1'b1;
            end else if (mmio_we && is_stat && bus.write_data[0]) begin
                flag_q <= 1'b0;
            end
        end
    end

    assign timer_irq = flag_q;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        if (!mmio_sel) begin
            rdata = ram[ram_idx];
        end else begin
            unique case (1'b1)
                is_gpio: rdata = gpio_q;
`ifdef DMEM_TIMER_EN
                is_cnt:  rdata = cnt_q;
                is_cmp:  rdata = cmp_q;
                is_stat: rdata = {{(WIDTH-1){1'b0}}, flag_q};
`endif
                default: rdata = '0;
            endcase
        end
    end

    assign bus.read_data = rdata;
endmodule

// File: tb/tb_data_mem_mmio.sv
// Self-checking bench for data_mem_mmio with a behavioural memory/MMIO model.
// Timer cases run only when DMEM_TIMER_EN is defined; otherwise the timer-off cases run.
module tb_data_mem_mmio;
`ifdef DMEM_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] gpio_out;
    logic        timer_irq;

    data_mem_mmio_if #(.WIDTH(32)) bus ();

    data_mem_mmio dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state: plain words, indexed by byte address modulo 256
    logic [31:0] m_ram   [64];
    bit          m_valid [64];
    logic [31:0] m_gpio, m_cnt, m_cmp;
    bit          m_flag;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic [31:0] a, d;
        bit          hit;
        a = bus.addr;
        d = bus.write_data;
        if (reset) begin
            m_gpio = 32'h0;
            m_cnt  = 32'h0;
            m_cmp  = 32'hFFFF_FFFF;
            m_flag = 1'b0;
        end else begin
            hit   = (m_cnt == m_cmp);
            m_cnt = m_cnt + 32'd1;
            if (bus.mem_write && (a % 4 == 0)) begin
                if (a[31:16] == 16'hFFFF) begin
                    if (a[15:0] == 16'h0000) m_gpio = d;
                    if (a[15:0] == 16'h0004) m_cnt = d;
                    if (a[15:0] == 16'h0008) m_cmp = d;
                    if (a[15:0] == 16'h000C && d[0]) m_flag = 1'b0;
                end else begin
                    m_ram[(a % 256) / 4]   = d;
                    m_valid[(a % 256) / 4] = 1'b1;
                end
            end
            if (hit) m_flag = 1'b1;
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic [31:0] a;
        logic [31:0] er;
        bit          known;
        if (chk_en) begin
            a = bus.addr;
            known = 1'b1;
            er = 32'h0;
            if (a[31:16] == 16'hFFFF) begin
                case (a[15:0])
                    16'h0000: er = m_gpio;
                    16'h0004: er = TIMER_EN ? m_cnt : 32'h0;
                    16'h0008: er = TIMER_EN ? m_cmp : 32'h0;
                    16'h000C: er = TIMER_EN ? {31'h0, m_flag} : 32'h0;
                    default:  er = 32'h0;
                endcase
            end else begin
                known = m_valid[(a % 256) / 4];
                er = m_ram[(a % 256) / 4];
            end
            if (known) chk("model_read", bus.read_data, er);
            chk("model_gpio", gpio_out, m_gpio);
            chk("model_irq", {31'h0, timer_irq},
                {31'h0, TIMER_EN & m_flag});
            chk("model_misal", {31'h0, bus.misaligned},
                {31'h0, bus.mem_write && (a % 4 != 0)});
        end
    end

    task automatic set(input logic [31:0] a, input logic [31:0] d,
                       input logic w);
        bus.addr       = a;
        bus.write_data = d;
        bus.mem_write  = w;
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        reset          = 1'b1;
        bus.addr       = 32'h0;
        bus.write_data = 32'h0;
        bus.mem_write  = 1'b0;
        repeat (3) step();
        reset  = 1'b0;
        chk_en = 1'b1;

        set(32'h0, 32'h0, 1'b0);
        chk("rst_gpio", gpio_out, 32'h0);
        chk("rst_irq", {31'h0, timer_irq}, 32'h0);
        step();

        // RAM store, load, alias, same-cycle old value
        set(32'h10, 32'hDEADBEEF, 1'b1); step();
        set(32'h10, 32'h0, 1'b0);
        chk("ram_load", bus.read_data, 32'hDEADBEEF); step();
        set(32'h110, 32'h0, 1'b0);
        chk("ram_alias", bus.read_data, 32'hDEADBEEF); step();
        set(32'h10, 32'h11112222, 1'b1);
        chk("ram_old", bus.read_data, 32'hDEADBEEF); step();
        set(32'h10, 32'h0, 1'b0);
        chk("ram_new", bus.read_data, 32'h11112222); step();

        // Misaligned store is dropped
        set(32'h20, 32'h55, 1'b1); step();
        set(32'h22, 32'h1234, 1'b1);
        chk("misal_on", {31'h0, bus.misaligned}, 32'h1); step();
        set(32'h20, 32'h0, 1'b0);
        chk("misal_off", {31'h0, bus.misaligned}, 32'h0);
        chk("misal_ram", bus.read_data, 32'h55); step();

        // GPIO, misaligned MMIO store, unmapped offset
        set(32'hFFFF0000, 32'hA5, 1'b1); step();
        set(32'hFFFF0000, 32'h0, 1'b0);
        chk("gpio_out", gpio_out, 32'hA5);
        chk("gpio_rd", bus.read_data, 32'hA5); step();
        set(32'hFFFF0002, 32'hFF, 1'b1); step();
        set(32'hFFFF0010, 32'h7, 1'b1);
        chk("gpio_misal", gpio_out, 32'hA5); step();
        set(32'hFFFF0010, 32'h0, 1'b0);
        chk("unmapped", bus.read_data, 32'h0); step();

        // Stores during reset are ignored
        reset = 1'b1;
        set(32'hFFFF0000, 32'h3C, 1'b1); step();
        set(32'h10, 32'h999, 1'b1); step();
        reset = 1'b0;
        set(32'h10, 32'h0, 1'b0);
        chk("rst_gpio2", gpio_out, 32'h0);
        chk("rst_ram", bus.read_data, 32'h11112222); step();

        if (TIMER_EN) begin
            // Match: irq one cycle after CNT reads 5
            set(32'hFFFF0008, 32'd5, 1'b1); step();
            set(32'hFFFF0004, 32'd0, 1'b1); step();
            for (int i = 0; i < 5; i++) begin
                set(32'hFFFF0004, 32'h0, 1'b0);
                chk("cnt_run", bus.read_data, i);
                chk("irq_low", {31'h0, timer_irq}, 32'h0); step();
            end
            set(32'hFFFF0004, 32'h0, 1'b0);
            chk("cnt_5", bus.read_data, 32'd5);
            chk("irq_at5", {31'h0, timer_irq}, 32'h0); step();
            set(32'hFFFF000C, 32'h0, 1'b0);
            chk("irq_set", {31'h0, timer_irq}, 32'h1);
            chk("stat_set", bus.read_data, 32'h1); step();
            set(32'hFFFF000C, 32'h1, 1'b1); step();
            set(32'hFFFF000C, 32'h0, 1'b0);
            chk("irq_clr", {31'h0, timer_irq}, 32'h0); step();

            // W1C in the match cycle: set wins
            set(32'hFFFF0008, 32'd50, 1'b1); step();
            set(32'hFFFF0004, 32'd48, 1'b1); step();
            set(32'hFFFF0004, 32'h0, 1'b0);
            chk("cnt_48", bus.read_data, 32'd48); step();
            step();
            set(32'hFFFF000C, 32'h1, 1'b1);
            chk("stat_pre", bus.read_data, 32'h0); step();
            set(32'hFFFF000C, 32'h0, 1'b0);
            chk("collide", {31'h0, timer_irq}, 32'h1); step();

            // Counter wrap
            set(32'hFFFF0004, 32'hFFFF_FFFF, 1'b1); step();
            set(32'hFFFF0004, 32'h0, 1'b0);
            chk("cnt_max", bus.read_data, 32'hFFFF_FFFF); step();
            chk("cnt_wrap", bus.read_data, 32'h0); step();
        end else begin
            set(32'hFFFF0004, 32'h1234, 1'b1); step();
            set(32'hFFFF0008, 32'h5, 1'b1); step();
            set(32'hFFFF0004, 32'h0, 1'b0);
            repeat (100) step();
            chk("off_cnt", bus.read_data, 32'h0);
            set(32'hFFFF0008, 32'h0, 1'b0);
            chk("off_cmp", bus.read_data, 32'h0);
            chk("off_irq", {31'h0, timer_irq}, 32'h0); step();
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
